mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter sharing the single data memory (mem_data) between the processor (port 0)
//  and a second master (port 1: loader/debug). Picks one request per cycle, muxes it onto the
//  memory, returns registered read data. Supports locked bursts with a forced-release timeout.
// PARAMETERS
//  ADDR_W    8   data memory address width
//  DATA_W    32  data word width
//  LOCK_MAX  16  max consecutive cycles one port may hold a lock (>=2)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  pN_req     in   1       port N (N=0,1) access request; held until pN_gnt sampled high
//  pN_wr      in   1       1 = write, 0 = read; held with req
//  pN_lock    in   1       request exclusive ownership (burst) while high
//  pN_addr    in   ADDR_W  word address; held with req
//  pN_wdata   in   DATA_W  write data; held with req
//  pN_gnt     out  1       combinational: access performed at this clock edge
//  pN_rvalid  out  1       registered: pN_rdata valid (cycle after a granted read)
//  pN_rdata   out  DATA_W  registered read data
//  lock_abort out  1       registered 1-cycle pulse: lock forcibly released by timeout
//  mem_wr     out  1       data memory write enable
//  mem_addr   out  ADDR_W  data memory address
//  mem_wdata  out  DATA_W  data memory write data
//  mem_rdata  in   DATA_W  data memory read data (combinational read)
// BEHAVIOUR
//  - Reset (rst=0 at edge): state=IDLE, last=1, lock_cnt=0, pN_rvalid=0, pN_rdata=0,
//    lock_abort=0. While rst=0, pN_gnt=0 and mem_wr=0 (combinationally gated).
//  - States: IDLE, OWN0, OWN1. In IDLE either port may win; in OWNx only port x is eligible.
//  - Winner (IDLE): one req -> that port; both -> per arbitration policy (CONFIGURATION).
//  - Winner drives mem_addr/mem_wdata; mem_wr = winner wr. No winner: mem_wr=0, addr/wdata=port 0.
//  - Granted read: pN_rdata <= mem_rdata, pN_rvalid=1 next cycle only (latency 1). Write: no rvalid.
//  - last <= winner index on every grant.
//  - IDLE -> OWNx at edge where port x granted with px_lock=1; lock_cnt <= 1.
//  - OWNx: lock_cnt++ each cycle; at edge with px_lock=0 -> IDLE, lock_cnt=0.
//  - OWNx with lock_cnt==LOCK_MAX-1 and px_lock=1 -> IDLE, lock_abort=1 next cycle, last=x
//    (other port favoured); locking port may not re-lock in the next cycle.
//  - OWNx and px_req=0: no grant, memory idle, ownership kept (counter still runs).
//  - Other port's req while OWNx: held off, no gnt, no loss of request.
//  - Reset mid-burst: ownership dropped, in-flight rvalid suppressed.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: simultaneous IDLE requests -> port != last wins.
//  Not defined: fixed priority, port 0 always wins; port 1 starves while port 0 requests.
//  Lock/timeout identical in both builds.
// STRUCTURE
//  Package mem_arb_pkg: state enum typedef (IDLE/OWN0/OWN1), port index constants P0/P1,
//  default ADDR_W/DATA_W.
//  Sub-module mem_arb_pick: combinational winner select (reqs, state, last -> gnt vector).
//  Top holds FSM, lock counter, memory mux, rdata/rvalid registers.
// TESTING
//  1 rst=0 two cycles, both reqs high -> no gnt, mem_wr=0; after release rvalid=0, rdata=0.
//  2 p0 write addr 0x10 data 0x12345678, then p0 read 0x10 -> gnt each cycle, p0_rvalid=1,
//    p0_rdata=0x12345678 one cycle after read grant.
//  3 both req reads every cycle: RR build -> gnt alternates p0,p1,p0...; fixed build -> p0 only.
//  4 p1 locked burst of 4 writes (0x20-0x23) with p0 req high -> p0_gnt=0 for 4 cycles,
//    p0 granted the cycle after p1_lock drops.
//  5 p0 holds lock and req for 20 cycles, LOCK_MAX=16 -> IDLE after 15 cycles, lock_abort
//    pulses once, p1 granted next cycle.
//  6 rst=0 during OWN1 with pending read -> state IDLE, no p1_rvalid after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t      : arbiter ownership state (IDLE / OWN0 / OWN1)
//   P0, P1       : port index constants used to index grant vectors
//   ADDR_W_DEF   : default word-address width
//   DATA_W_DEF   : default data width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break when
// both ports request in IDLE; otherwise port 0 has fixed priority).
// Ports:
//   req          in  [1:0] request vector, bit N = port N
//   state        in        current ownership state; OWNx restricts eligibility to port x
//   last         in        index of the most recently granted port
//   favour_other in        set in the cycle after a forced lock release; the
//                          port that lost the lock yields to the other one
//   gnt          out [1:0] one-hot (or zero) winner vector
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  state_t     state,
  input  logic       last,
  input  logic       favour_other,
  output logic [1:0] gnt
);

  logic [1:0] elig;
  logic       use_last;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    use_last = 1'b1;
`else
    // Fixed priority, except right after a timeout when the aborted port
    // (recorded in last) must give way.
    use_last = favour_other;
`endif

    elig = req;
    case (state)
      OWN0:    elig = req & 2'b01;
      OWN1:    elig = req & 2'b10;
      default: elig = req;
    endcase

    gnt = elig;
    if (elig == 2'b11) begin
      gnt = (use_last && !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the data memory between the processor (port 0)
// and a loader/debug master (port 1). One access per cycle, registered read
// data with latency 1, locked bursts with a forced-release timeout.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   pN_req/wr/lock/addr/wdata port N request, direction, burst lock, address, write data
//   pN_gnt                   combinational grant (access performed this edge)
//   pN_rvalid/pN_rdata       registered read response
//   lock_abort               1-cycle pulse after a lock timed out
//   mem_wr/addr/wdata/rdata  data memory interface (combinational read)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              lock_abort,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     CW       = $clog2(LOCK_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'(LOCK_MAX - 1);

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          abort_nx;
  logic          own_lock;
  logic [1:0]    pick;
  logic [1:0]    gnt;

  mem_arb_pick u_pick (
    .req          ({p1_req, p0_req}),
    .state        (state),
    .last         (last),
    .favour_other (lock_abort),
    .gnt          (pick)
  );

  assign gnt    = rst ? pick : '0;
  assign p0_gnt = gnt[P0];
  assign p1_gnt = gnt[P1];

  always_comb begin
    mem_addr  = p0_addr;
    mem_wdata = p0_wdata;
    mem_wr    = 1'b0;
    if (gnt[P1]) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wr    = p1_wr;
    end else if (gnt[P0]) begin
      mem_wr    = p0_wr;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    abort_nx = 1'b0;
    last_nx  = (|gnt) ? gnt[P1] : last;
    own_lock = (state == OWN1) ? p1_lock : p0_lock;

    case (state)
      IDLE: begin
        // In the cycle after a timeout the aborted port (== last) may be
        // granted but cannot take the lock again.
        if (gnt[P0] && p0_lock && !(lock_abort && !last)) begin
          state_nx = OWN0;
          cnt_nx   = CW'(1);
        end else if (gnt[P1] && p1_lock && !(lock_abort && last)) begin
          state_nx = OWN1;
          cnt_nx   = CW'(1);
        end
      end
      OWN0, OWN1: begin
        if (!own_lock) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          abort_nx = 1'b1;
          last_nx  = (state == OWN1);
        end else begin
          cnt_nx   = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cnt        <= '0;
      lock_abort <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state      <= state_nx;
      last       <= last_nx;
      cnt        <= cnt_nx;
      lock_abort <= abort_nx;
      p0_rvalid  <= gnt[P0] & ~p0_wr;
      p1_rvalid  <= gnt[P1] & ~p1_wr;
      if (gnt[P0] && !p0_wr) p0_rdata <= mem_rdata;
      if (gnt[P1] && !p1_wr) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all checked against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int          LM = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_wr, p0_lock, p1_req, p1_wr, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, lock_abort, mem_wr;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] tb_mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .lock_abort(lock_abort), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_wr) tb_mem[mem_addr] <= mem_wdata;

  // Reference model state
  int            owner = -1;   // port holding the lock, -1 = nobody
  int            held  = 0;    // cycles the lock has been held
  int            last  = 1;
  bit            ab    = 1'b0; // abort pulse expected this cycle
  bit            erv0 = 1'b0, erv1 = 1'b0;
  logic [DW-1:0] erd0 = '0, erd1 = '0;
  logic [DW-1:0] ref_mem [256];
  bit            eg0, eg1, ewr;
  logic [AW-1:0] eaddr;
  logic [DW-1:0] ewdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_comb();
    int w;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst) begin
      if (owner == 0)      eg0 = p0_req;
      else if (owner == 1) eg1 = p1_req;
      else if (p0_req && p1_req) begin
        w   = (RR || ab) ? 1 - last : 0;
        eg0 = (w == 0);
        eg1 = (w == 1);
      end else begin
        eg0 = p0_req;
        eg1 = p1_req;
      end
    end
    ewr    = eg1 ? p1_wr : (eg0 ? p0_wr : 1'b0);
    eaddr  = eg1 ? p1_addr : p0_addr;
    ewdata = eg1 ? p1_wdata : p0_wdata;
  endtask

  task automatic model_edge();
    int w, old_last;
    bit wlock, ol, old_ab, nab;
    if (!rst) begin
      owner = -1; held = 0; last = 1; ab = 1'b0;
      erv0 = 1'b0; erv1 = 1'b0; erd0 = '0; erd1 = '0;
      return;
    end
    w        = eg1 ? 1 : (eg0 ? 0 : -1);
    wlock    = (w == 1) ? p1_lock : p0_lock;
    old_last = last;
    old_ab   = ab;
    nab      = 1'b0;
    erv0 = eg0 && !p0_wr;
    erv1 = eg1 && !p1_wr;
    if (erv0) erd0 = ref_mem[p0_addr];
    if (erv1) erd1 = ref_mem[p1_addr];
    if (ewr) ref_mem[eaddr] = ewdata;
    if (w >= 0) last = w;
    if (owner >= 0) begin
      ol = (owner == 1) ? p1_lock : p0_lock;
      if (!ol) begin
        owner = -1; held = 0;
      end else if (held == LM - 1) begin
        nab = 1'b1; last = owner; owner = -1; held = 0;
      end else begin
        held++;
      end
    end else if (w >= 0 && wlock && !(old_ab && w == old_last)) begin
      owner = w; held = 1;
    end
    ab = nab;
  endtask

  // One clock: combinational checks at negedge, registered checks after posedge.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    chk("p0_gnt", DW'(p0_gnt), DW'(eg0));
    chk("p1_gnt", DW'(p1_gnt), DW'(eg1));
    chk("mem_wr", DW'(mem_wr), DW'(ewr));
    chk("mem_addr", DW'(mem_addr), DW'(eaddr));
    if (ewr) chk("mem_wdata", mem_wdata, ewdata);
    @(posedge clk);
    model_edge();
    #1;
    chk("p0_rvalid", DW'(p0_rvalid), DW'(erv0));
    chk("p1_rvalid", DW'(p1_rvalid), DW'(erv1));
    chk("p0_rdata", p0_rdata, erd0);
    chk("p1_rdata", p1_rdata, erd1);
    chk("lock_abort", DW'(lock_abort), DW'(ab));
  endtask

  task automatic idle_ports();
    p0_req = 0; p0_wr = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wr = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  initial begin
    int aborts;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = DW'(i * 32'h01010101 + 32'h5a);
      ref_mem[i] = DW'(i * 32'h01010101 + 32'h5a);
    end
    idle_ports();
    rst = 1'b0;

    // 1: reset with both ports requesting
    p0_req = 1; p1_req = 1; p0_wr = 1; p1_wr = 1;
    repeat (2) cycle();
    chk("reset_p0_rdata", p0_rdata, '0);
    rst = 1'b1;
    idle_ports();
    cycle();

    // 2: write then read back on port 0
    p0_req = 1; p0_wr = 1; p0_addr = 8'h10; p0_wdata = 32'h12345678;
    cycle();
    p0_wr = 0;
    cycle();
    p0_req = 0;
    chk("p0_readback", p0_rdata, 32'h12345678);
    chk("p0_readback_valid", DW'(p0_rvalid), DW'(1));

    // 3: contention, both ports read every cycle
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 6; i++) begin
      p0_addr = AW'($urandom_range(255));
      p1_addr = AW'($urandom_range(255));
      cycle();
    end
    idle_ports();
    cycle();

    // 4: port 1 locked burst of writes while port 0 waits
    p1_req = 1; p1_lock = 1; p1_wr = 1; p1_addr = 8'h20; p1_wdata = $urandom;
    cycle();
    p0_req = 1; p0_addr = 8'h30;
    for (int i = 1; i < 4; i++) begin
      p1_addr = AW'(8'h20 + i); p1_wdata = $urandom;
      cycle();
      chk("burst_p0_held", DW'(p0_gnt), DW'(0));
    end
    p1_req = 0; p1_lock = 0; p1_wr = 0;
    cycle();
    cycle();
    chk("burst_p0_after", DW'(p0_gnt), DW'(1));
    idle_ports();
    cycle();

    // 5: port 0 holds its lock past the timeout while port 1 waits
    aborts = 0;
    p0_req = 1; p0_lock = 1; p0_addr = 8'h21;
    cycle();
    p1_req = 1; p1_addr = 8'h22;
    for (int i = 1; i < 20; i++) begin
      cycle();
      if (lock_abort) aborts++;
      if (eg1) p1_req = 0;
    end
    chk("abort_once", DW'(aborts), DW'(1));
    idle_ports();
    cycle();

    // 6: reset while port 1 owns the bus with a read in flight
    p1_req = 1; p1_lock = 1; p1_addr = 8'h21;
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1; p1_req = 0; p1_lock = 0;
    p0_req = 1; p0_addr = 8'h20;
    cycle();
    chk("post_reset_p1_rvalid", DW'(p1_rvalid), DW'(0));
    idle_ports();

    // Randomized traffic; requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (!p0_req || eg0) begin
        p0_req = ($urandom_range(3) != 0); p0_wr = $urandom_range(1);
        p0_addr = AW'($urandom_range(15)); p0_wdata = $urandom;
      end
      if (!p1_req || eg1) begin
        p1_req = ($urandom_range(3) != 0); p1_wr = $urandom_range(1);
        p1_addr = AW'($urandom_range(15)); p1_wdata = $urandom;
      end
      if (p0_lock) p0_lock = ($urandom_range(15) != 0); else p0_lock = ($urandom_range(5) == 0);
      if (p1_lock) p1_lock = ($urandom_range(15) != 0); else p1_lock = ($urandom_range(5) == 0);
      rst = ($urandom_range(99) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
